dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port. Serves one load/store at a time over a valid/ready request channel and a single-cycle response pulse, with configurable access latency.
- Sits between the EX/MEM stage (the initiator) and a word-addressed storage array.
- Supplies the `busy` stall indication that the hazard logic uses to freeze PC, IF/ID and the later pipeline registers while an access is in flight.

---
 rtl/mem_pkg.sv | 14 +
 rtl/dmem_responder_if.sv | 17 +
 rtl/dmem_array.sv | 18 +
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int WORD_BYTES = 4;

  // Flags a byte offset that is not word-aligned or lands past the last word.
  function automatic logic addr_err(input logic [31:0] off, input int unsigned depth);
    return ((off & 32'(WORD_BYTES - 1)) != 32'h0) ||
           ((off >> $clog2(WORD_BYTES)) >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the EX/MEM initiator and the memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err, busy);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err, busy);
endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word storage; no reset so it maps onto block RAM.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dmem_responder.sv
// Serial load/store responder: accepts one request, waits LATENCY cycles,
// commits on the edge entering RESP and pulses a one-cycle response.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             RESET,
  dmem_responder_if.slave  bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, rerr_q, rload_q;
  logic [31:0] addr_q, wdata_q;
  logic        xfer, commit, cur_write, cur_err;
  logic [31:0] cur_addr, cur_wdata, off, ram_rdata;

  assign bus.req_ready = (state_q == IDLE) && RESET;
  assign xfer          = bus.req_valid && bus.req_ready;

  // With zero latency the commit edge is the accepting edge, so the live
  // request drives the array and address check while still in IDLE.
  assign cur_write = (state_q == IDLE) ? bus.req_write : write_q;
  assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign off       = cur_addr - ADDR_BASE;
  assign cur_err   = addr_err(off, DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (xfer) begin
        if (LATENCY == 0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rerr_q  <= 1'b0;
      rload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (xfer) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rerr_q  <= cur_err;
        rload_q <= !cur_write && !cur_err;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .CLK     (CLK),
    .we_i    (commit && cur_write && !cur_err),
    .addr_i  (off[AW+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  // Response fields are forced to zero outside the RESP pulse.
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = bus.resp_valid && rerr_q;
  assign bus.resp_rdata = (bus.resp_valid && rload_q) ? ram_rdata : 32'h0;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 0, 4) driven by directed vectors.
module tb_dmem_responder;
  localparam int N = 3;

  function automatic int unsigned lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0] rst_n, rv, rw, rdy, vld, er, bsy;
  logic [31:0]  ra [N];
  logic [31:0]  wd [N];
  logic [31:0]  rd [N];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   runlen [N];
  exp_t q0[$], q1[$], q2[$];

  always @(posedge CLK) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder_if bus();
    assign bus.req_valid = rv[g];
    assign bus.req_write = rw[g];
    assign bus.req_addr  = ra[g];
    assign bus.req_wdata = wd[g];
    assign rdy[g] = bus.req_ready;
    assign vld[g] = bus.resp_valid;
    assign er[g]  = bus.resp_err;
    assign rd[g]  = bus.resp_rdata;
    assign bsy[g] = bus.busy;
    dmem_responder #(.DEPTH(256), .LATENCY(lat_of(g)), .ADDR_BASE(32'h0)) u_dut (
      .CLK   (CLK),
      .RESET (rst_n[g]),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got 0x%08h, expected 0x%08h", nm, d, cyc, act, exp);
    end
  endtask

  // Monitor: response pops from the scoreboard, plus per-cycle invariants.
  always @(negedge CLK) begin
    for (int d = 0; d < N; d++) begin
      exp_t e;
      bit   have;
      if (!rst_n[d]) begin
        chk("rst_ready", d, 32'(rdy[d]), 32'h0);
        chk("rst_valid", d, 32'(vld[d]), 32'h0);
        chk("rst_busy",  d, 32'(bsy[d]), 32'h0);
        chk("rst_err",   d, 32'(er[d]),  32'h0);
        chk("rst_rdata", d, rd[d],       32'h0);
        runlen[d] = 0;
      end else begin
        chk("ready_vs_busy", d, 32'(rdy[d]), 32'(!bsy[d]));
        if (bsy[d]) runlen[d]++;
        else if (runlen[d] != 0) begin
          chk("busy_len", d, runlen[d], lat_of(d) + 1);
          runlen[d] = 0;
        end
        if (vld[d]) begin
          case (d)
            0:       have = q0.size() > 0;
            1:       have = q1.size() > 0;
            default: have = q2.size() > 0;
          endcase
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp dut%0d cyc %0d: got resp_valid=1, expected no response", d, cyc);
          end else begin
            case (d)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            chk("resp_rdata", d, rd[d], e.rd);
            chk("resp_err",   d, 32'(er[d]), 32'(e.er));
            chk("resp_cycle", d, cyc, e.cyc);
          end
        end else begin
          chk("idle_rdata", d, rd[d], 32'h0);
          chk("idle_err",   d, 32'(er[d]), 32'h0);
        end
      end
    end
  end

  // Call at a negedge. Returns at a negedge; acc is the accepting edge number.
  task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] xr, input bit xe, input bit want, input bit hold,
                       input bit tog, output int acc);
    int   n = 0;
    exp_t e;
    rw[d] = wr; ra[d] = a; wd[d] = w; rv[d] = 1'b1;
    while (!rdy[d] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!rdy[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d addr 0x%08h: got no req_ready in 50 cycles, expected acceptance", d, a);
      rv[d] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (want) begin
      e.rd = xr; e.er = xe; e.cyc = acc + int'(lat_of(d));
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge CLK);
    @(negedge CLK);
    if (tog) begin
      n = 0;
      while (!rdy[d] && n < 50) begin
        rw[d] = 1'($urandom_range(1, 0)); ra[d] = $urandom; wd[d] = $urandom; rv[d] = 1'b1;
        @(negedge CLK);
        n++;
      end
      rv[d] = 1'b0;
    end else if (!hold) begin
      rv[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    int accs [4];
    rst_n = '0; rv = '0; rw = '0;
    for (int d = 0; d < N; d++) begin ra[d] = 32'h0; wd[d] = 32'h0; runlen[d] = 0; end
    repeat (3) @(posedge CLK);
    #1 rst_n = '1;
    @(negedge CLK);

    // LATENCY=2: store/load, misaligned, out-of-range, boundary, ignored-while-busy.
    issue(0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1, 0, 0, t);
    issue(0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, 0, 0, t);
    issue(0, 1, 32'h13,  32'h1234,     32'h0,        1, 1, 0, 0, t);
    issue(0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, 0, 0, t);
    issue(0, 0, 32'h400, 32'h0,        32'h0,        1, 1, 0, 0, t);
    issue(0, 1, 32'h3FC, 32'hA5A55A5A, 32'h0,        0, 1, 0, 0, t);
    issue(0, 0, 32'h3FC, 32'h0,        32'hA5A55A5A, 0, 1, 0, 0, t);
    issue(0, 1, 32'h40,  32'h11111111, 32'h0,        0, 1, 0, 1, t);
    issue(0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, 0, 1, t);
    issue(0, 0, 32'h40,  32'h0,        32'h11111111, 0, 1, 0, 0, t);

    // LATENCY=0: seed four words, then back-to-back loads with valid held.
    for (int i = 0; i < 4; i++)
      issue(1, 1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 32'h0, 0, 1, 0, 0, t);
    for (int i = 0; i < 4; i++)
      issue(1, 0, 32'(i * 4), 32'h0, 32'hC0DE0000 + 32'(i), 0, 1, (i < 3), 0, accs[i]);
    for (int i = 1; i < 4; i++) chk("b2b_gap", 1, accs[i] - accs[i-1], 2);

    // LATENCY=4: reset two cycles into a store aborts it.
    issue(2, 1, 32'h20, 32'h01234567, 32'h0, 0, 1, 0, 0, t);
    issue(2, 1, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0, t);
    @(posedge CLK);
    @(posedge CLK);
    #1 rst_n[2] = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst_n[2] = 1'b1;
    @(negedge CLK);
    issue(2, 0, 32'h20, 32'h0, 32'h01234567, 0, 1, 0, 0, t);

    repeat (10) @(negedge CLK);
    chk("q_empty", 0, q0.size(), 0);
    chk("q_empty", 1, q1.size(), 0);
    chk("q_empty", 2, q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
